// File: rtl/fib_sequencer_if.sv
// Control and output-stream bundle for fib_sequencer.
// The sequencer takes the slave side; the controller or sink takes the master side.
interface fib_sequencer_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MAX_TERMS = 64
);
  localparam int unsigned CW = $clog2(MAX_TERMS + 1);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] seed_a;
  logic [WIDTH-1:0] seed_b;
  logic [CW-1:0]    num_terms;
  logic [1:0]       mode;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_index;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             overflow;

  modport master (
    output start, abort, seed_a, seed_b, num_terms, mode, out_ready,
    input  out_data, out_index, out_valid, busy, done, overflow
  );

  modport slave (
    input  start, abort, seed_a, seed_b, num_terms, mode, out_ready,
    output out_data, out_index, out_valid, busy, done, overflow
  );
endinterface

// File: rtl/fib_sequencer.sv
// Fibonacci-type sequence source: t[0]=seed_b, t[1]=seed_a, t[k+2]=t[k]+t[k+1],
// streamed over valid/ready with wrap, saturate or stop-on-overflow policy.
module fib_sequencer #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MAX_TERMS = 64
) (
  input  logic           clock,
  input  logic           reset_n,
  fib_sequencer_if.slave bus
);
  localparam int unsigned CW = $clog2(MAX_TERMS + 1);
  localparam logic [1:0] MODE_SAT  = 2'd1;
  localparam logic [1:0] MODE_STOP = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             a_tag_q, a_tag_d;
  logic [CW-1:0]    num_q, num_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] data_d;
  logic [CW-1:0]    index_d;
  logic             valid_d, busy_d, done_d, ovf_d;
  logic [WIDTH:0]   sum;
  logic [CW-1:0]    num_clamped;

  // Next term; bit WIDTH is the carry that gets tagged onto the a-register.
  assign sum = {1'b0, a_q} + {1'b0, bus.out_data};
  assign num_clamped = (bus.num_terms > CW'(MAX_TERMS)) ? CW'(MAX_TERMS) : bus.num_terms;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    a_tag_d = a_tag_q;
    num_d   = num_q;
    mode_d  = mode_q;
    data_d  = bus.out_data;
    index_d = bus.out_index;
    ovf_d   = bus.overflow;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          num_d   = num_clamped;
          mode_d  = bus.mode;
          data_d  = bus.seed_b;
          a_d     = bus.seed_a;
          a_tag_d = 1'b0;
          index_d = '0;
          ovf_d   = 1'b0;
          state_d = (num_clamped == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // abort outranks an accept in the same cycle
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.out_valid && bus.out_ready) begin
          if (bus.out_index == CW'(num_q - CW'(1))) begin
            state_d = S_DONE;
          end else if (mode_q == MODE_STOP && a_tag_q) begin
            state_d = S_DONE;
            ovf_d   = 1'b1;
          end else begin
            data_d  = a_q;
            index_d = CW'(bus.out_index + CW'(1));
            ovf_d   = bus.overflow | a_tag_q;
            a_tag_d = sum[WIDTH];
            a_d     = (sum[WIDTH] && mode_q == MODE_SAT) ? '1 : sum[WIDTH-1:0];
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    valid_d = (state_d == S_RUN);
    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      a_q           <= '0;
      a_tag_q       <= 1'b0;
      num_q         <= '0;
      mode_q        <= '0;
      bus.out_data  <= '0;
      bus.out_index <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      a_tag_q       <= a_tag_d;
      num_q         <= num_d;
      mode_q        <= mode_d;
      bus.out_data  <= data_d;
      bus.out_index <= index_d;
      bus.out_valid <= valid_d;
      bus.busy      <= busy_d;
      bus.done      <= done_d;
      bus.overflow  <= ovf_d;
    end
  end
endmodule

// File: tb/tb_fib_sequencer.sv
// Scoreboard bench for fib_sequencer at WIDTH=8: directed runs push expected terms,
// a negedge monitor pops and compares every accepted term.
module tb_fib_sequencer;
  localparam int unsigned W  = 8;
  localparam int unsigned MT = 64;
  localparam int unsigned CW = $clog2(MT + 1);

  typedef struct {
    int unsigned data;
    int unsigned idx;
    bit          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   compared = 0;
  int   mismatched = 0;
  exp_t exp_q[$];

  logic [W-1:0]  prev_data;
  logic [CW-1:0] prev_idx;
  bit            held = 1'b0;

  int unsigned fib_w[16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};
  int unsigned fib_s[16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 255, 255};
  int unsigned lucas[6]  = '{2, 1, 3, 4, 7, 11};

  fib_sequencer_if #(.WIDTH(W), .MAX_TERMS(MT)) bus ();

  fib_sequencer #(.WIDTH(W), .MAX_TERMS(MT)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic push(input int unsigned d, input int unsigned i, input bit o);
    exp_t e;
    e.data = d;
    e.idx  = i;
    e.ovf  = o;
    exp_q.push_back(e);
  endtask

  // Monitor: pop on every accepted term; a held term must stay stable
  always @(negedge clk) begin
    if (reset_n) begin
      if (held)
        check($sformatf("hold idx%0d", prev_idx),
              64'({bus.out_valid, bus.out_data, bus.out_index}),
              64'({1'b1, prev_data, prev_idx}));
      if (bus.out_valid && bus.out_ready && !bus.abort) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected term: got data %0d idx %0d, expected none",
                   bus.out_data, bus.out_index);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check($sformatf("term idx%0d {data,idx,ovf}", e.idx),
                64'({bus.out_data, bus.out_index, bus.overflow}),
                64'({W'(e.data), CW'(e.idx), e.ovf}));
        end
      end
    end
    held      = reset_n && bus.out_valid && !bus.out_ready && !bus.abort;
    prev_data = bus.out_data;
    prev_idx  = bus.out_index;
  end

  task automatic launch(input int unsigned sb, input int unsigned sa, input int unsigned n,
                        input logic [1:0] m, input logic rdy);
    @(posedge clk); #1;
    bus.seed_b    = W'(sb);
    bus.seed_a    = W'(sa);
    bus.num_terms = CW'(n);
    bus.mode      = m;
    bus.out_ready = rdy;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  // pat 0: ready always high; pat 1: ready 1,0,0 repeating
  task automatic wait_done(input string name, input int pat, input bit exp_ovf, input int exp_vc);
    int vc = 0;
    bit got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (bus.out_valid) vc++;
      bus.out_ready = (pat == 0) ? 1'b1 : (c % 3 == 0);
      @(posedge clk); #1;
    end
    check({name, " done seen"}, 64'(got), 64'(1));
    check({name, " overflow at done"}, 64'(bus.overflow), 64'(exp_ovf));
    check({name, " terms left"}, 64'(exp_q.size()), 64'(0));
    if (exp_vc >= 0) check({name, " valid cycles"}, 64'(vc), 64'(exp_vc));
    @(posedge clk); #1;
    check({name, " after done {done,busy,ovf,valid}"},
          64'({bus.done, bus.busy, bus.overflow, bus.out_valid}),
          64'({1'b0, 1'b0, exp_ovf, 1'b0}));
  endtask

  initial begin
    int dcnt;
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.seed_a    = '0;
    bus.seed_b    = '0;
    bus.num_terms = '0;
    bus.mode      = 2'd0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", 64'({bus.out_data, bus.out_index, bus.out_valid, bus.busy, bus.done, bus.overflow}), 64'(0));
    reset_n = 1'b1;

    // 1: plain sequence at full throughput
    for (int i = 0; i < 10; i++) push(fib_w[i], i, 1'b0);
    launch(0, 1, 10, 2'd0, 1'b1);
    wait_done("t1", 0, 1'b0, 10);

    // 2: wrap
    for (int i = 0; i < 16; i++) push(fib_w[i], i, i >= 14);
    launch(0, 1, 16, 2'd0, 1'b1);
    wait_done("t2 wrap", 0, 1'b1, 16);

    // 3: saturate
    for (int i = 0; i < 16; i++) push(fib_s[i], i, i >= 14);
    launch(0, 1, 16, 2'd1, 1'b1);
    wait_done("t3 sat", 0, 1'b1, 16);

    // 4: stop ends after 14 terms
    for (int i = 0; i < 14; i++) push(fib_w[i], i, 1'b0);
    launch(0, 1, 20, 2'd2, 1'b1);
    wait_done("t4 stop", 0, 1'b1, 14);

    // 5: Lucas with backpressure
    for (int i = 0; i < 6; i++) push(lucas[i], i, 1'b0);
    launch(2, 1, 6, 2'd0, 1'b1);
    wait_done("t5 lucas", 1, 1'b0, -1);

    // num=0
    launch(0, 1, 0, 2'd0, 1'b1);
    wait_done("num0", 0, 1'b0, 0);

    // abort at idx3
    for (int i = 0; i < 3; i++) push(fib_w[i], i, 1'b0);
    launch(0, 1, 10, 2'd0, 1'b1);
    for (int c = 0; c < 50; c++) begin
      if (bus.out_valid && bus.out_index == CW'(3)) begin
        bus.abort = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("abort reached idx3", 64'(bus.abort), 64'(1));
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort {valid,busy,done}", 64'({bus.out_valid, bus.busy, bus.done}), 64'(0));
    dcnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.done) dcnt++;
      @(posedge clk); #1;
    end
    check("abort no done", 64'(dcnt), 64'(0));
    check("abort terms left", 64'(exp_q.size()), 64'(0));

    // mid-run reset at idx5, overflow already set
    push(200, 0, 1'b0); push(100, 1, 1'b0); push(44, 2, 1'b1); push(144, 3, 1'b1); push(188, 4, 1'b1);
    launch(200, 100, 10, 2'd0, 1'b1);
    for (int c = 0; c < 50; c++) begin
      if (bus.out_valid && bus.out_index == CW'(5)) break;
      @(posedge clk); #1;
    end
    check("pre-reset idx5 {data,idx,ovf}", 64'({bus.out_data, bus.out_index, bus.overflow}),
          64'({8'd76, 7'd5, 1'b1}));
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("mid-run reset outputs",
          64'({bus.out_data, bus.out_index, bus.out_valid, bus.busy, bus.done, bus.overflow}), 64'(0));
    reset_n = 1'b1;
    check("reset terms left", 64'(exp_q.size()), 64'(0));

    // start while busy is ignored
    for (int i = 0; i < 5; i++) push(fib_w[i], i, 1'b0);
    launch(0, 1, 5, 2'd0, 1'b0);
    @(posedge clk); #1;
    bus.seed_b    = 8'd9;
    bus.seed_a    = 8'd9;
    bus.num_terms = CW'(1);
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    check("restart ignored {busy,data,idx}", 64'({bus.busy, bus.out_data, bus.out_index}),
          64'({1'b1, 8'd0, 7'd0}));
    wait_done("busy start", 0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
